// File: rtl/mem_responder.sv
// Word-addressed memory serving a core read/write port, with a host register
// window that can commit or fetch one word through a shadow register.
module mem_responder #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_read_en,
    input  logic [63:0]       i_read_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_rvalid,
    input  logic              i_write_en,
    input  logic [63:0]       i_write_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_reg_ctl,
    input  logic [31:0]       i_reg_addr,
    input  logic [31:0]       i_reg_data,
    output logic [31:0]       o_reg_data,
    output logic              o_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR_PEND = 2'd1;
    localparam logic [1:0] ST_RD_PEND = 2'd2;
    localparam logic [1:0] ST_RD_WAIT = 2'd3;

    localparam logic [1:0] CTL_READ  = 2'd1;
    localparam logic [1:0] CTL_WRITE = 2'd2;

    localparam logic [31:0] REG_STATUS   = 32'h0;
    localparam logic [31:0] REG_RCOUNT   = 32'h1;
    localparam logic [31:0] REG_WCOUNT   = 32'h2;
    localparam logic [31:0] REG_HADDR    = 32'h3;
    localparam logic [31:0] REG_HDATA_LO = 32'h4;
    localparam logic [31:0] REG_HDATA_HI = 32'h5;
    localparam logic [31:0] REG_CMD      = 32'h6;

    localparam logic [31:0] CMD_COMMIT = 32'd1;
    localparam logic [31:0] CMD_FETCH  = 32'd2;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    logic [1:0]        state;
    logic [31:0]       rcount;
    logic [31:0]       wcount;
    logic [31:0]       haddr;
    logic [63:0]       shadow;
    logic [DATA_W-1:0] host_rd_q;

    logic              core_rd_oor;
    logic              core_wr_oor;
    logic              host_oor;
    logic              host_busy;
    logic              reg_rd;
    logic              reg_wr;
    logic              host_wr_go;
    logic              host_rd_go;
    logic              err_set;
    logic              err_clr;
    logic              cmd_wr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] haddr_inc;
    logic [31:0]       reg_rdata;

    assign core_rd_oor = |i_read_addr[63:ADDR_W];
    assign core_wr_oor = |i_write_addr[63:ADDR_W];
    assign host_oor    = |haddr[31:ADDR_W];
    assign host_busy   = (state != ST_IDLE);
    assign reg_rd      = (i_reg_ctl == CTL_READ);
    assign reg_wr      = (i_reg_ctl == CTL_WRITE);

    // Host accesses only slip into cycles where the core leaves that port free.
    assign host_wr_go = (state == ST_WR_PEND) && !i_write_en;
    assign host_rd_go = (state == ST_RD_PEND) && !i_read_en;

    assign err_set = (i_read_en && core_rd_oor) || (i_write_en && core_wr_oor)
                   || ((host_wr_go || host_rd_go) && host_oor);
    assign err_clr = reg_wr && (i_reg_addr == REG_STATUS) && i_reg_data[0];
    assign cmd_wr  = reg_wr && (i_reg_addr == REG_CMD) && !host_busy;

    assign mem_we    = (i_write_en && !core_wr_oor) || (host_wr_go && !host_oor);
    assign mem_waddr = i_write_en ? i_write_addr[ADDR_W-1:0] : haddr[ADDR_W-1:0];
    assign mem_wdata = i_write_en ? i_data : shadow[DATA_W-1:0];
    assign haddr_inc = haddr[ADDR_W-1:0] + ADDR_W'(1);

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        reg_rdata = '0;
        case (i_reg_addr)
            REG_STATUS:   reg_rdata = {30'b0, host_busy, o_err};
            REG_RCOUNT:   reg_rdata = rcount;
            REG_WCOUNT:   reg_rdata = wcount;
            REG_HADDR:    reg_rdata = haddr;
            REG_HDATA_LO: reg_rdata = shadow[31:0];
            REG_HDATA_HI: reg_rdata = shadow[63:32];
            default:      reg_rdata = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rvalid   <= 1'b0;
            o_data     <= '0;
            o_reg_data <= '0;
            o_err      <= 1'b0;
            rcount     <= '0;
            wcount     <= '0;
            haddr      <= '0;
            shadow     <= '0;
            host_rd_q  <= '0;
            state      <= ST_IDLE;
        end else begin
            o_rvalid <= i_read_en;
            if (i_read_en)
                o_data <= core_rd_oor ? '0 : mem[i_read_addr[ADDR_W-1:0]];
            if (reg_rd)
                o_reg_data <= reg_rdata;

            if (err_set)
                o_err <= 1'b1;
            else if (err_clr)
                o_err <= 1'b0;

            if (i_read_en && (rcount != '1))
                rcount <= rcount + 32'd1;
            if (i_write_en && (wcount != '1))
                wcount <= wcount + 32'd1;

            if (reg_wr && !host_busy) begin
                case (i_reg_addr)
                    REG_HADDR:    haddr         <= i_reg_data;
                    REG_HDATA_LO: shadow[31:0]  <= i_reg_data;
                    REG_HDATA_HI: shadow[63:32] <= i_reg_data;
                    default: ;
                endcase
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_wr && (i_reg_data == CMD_COMMIT))
                        state <= ST_WR_PEND;
                    else if (cmd_wr && (i_reg_data == CMD_FETCH))
                        state <= ST_RD_PEND;
                end
                ST_WR_PEND: begin
                    if (host_wr_go) begin
                        haddr <= {{(32-ADDR_W){1'b0}}, haddr_inc};
                        state <= ST_IDLE;
                    end
                end
                ST_RD_PEND: begin
                    if (host_rd_go) begin
                        host_rd_q <= host_oor ? '0 : mem[haddr[ADDR_W-1:0]];
                        state     <= ST_RD_WAIT;
                    end
                end
                default: begin
                    shadow <= 64'(host_rd_q);
                    haddr  <= {{(32-ADDR_W){1'b0}}, haddr_inc};
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: the storage array is deliberately left out of reset; its contents are undefined after reset.
    always_ff @(posedge i_clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios for the core port,
// host register window and reset, followed by randomized core traffic.
module tb_mem_responder;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_read_en;
    logic [63:0]       i_read_addr;
    logic [DATA_W-1:0] o_data;
    logic              o_rvalid;
    logic              i_write_en;
    logic [63:0]       i_write_addr;
    logic [DATA_W-1:0] i_data;
    logic [1:0]        i_reg_ctl;
    logic [31:0]       i_reg_addr;
    logic [31:0]       i_reg_data;
    logic [31:0]       o_reg_data;
    logic              o_err;

    mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_read_en    (i_read_en),
        .i_read_addr  (i_read_addr),
        .o_data       (o_data),
        .o_rvalid     (o_rvalid),
        .i_write_en   (i_write_en),
        .i_write_addr (i_write_addr),
        .i_data       (i_data),
        .i_reg_ctl    (i_reg_ctl),
        .i_reg_addr   (i_reg_addr),
        .i_reg_data   (i_reg_data),
        .o_reg_data   (o_reg_data),
        .o_err        (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural reference: a word array, request counters and the sticky flag.
    logic [63:0] m_mem [DEPTH];
    logic [31:0] m_rcount;
    logic [31:0] m_wcount;
    logic        m_err;
    logic [63:0] m_last;

    int errors;
    int checks;

    function automatic bit oor(input logic [63:0] a);
        return a >= 64'(DEPTH);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_read_en    = 1'b0;
        i_read_addr  = '0;
        i_write_en   = 1'b0;
        i_write_addr = '0;
        i_data       = '0;
        i_reg_ctl    = 2'd0;
        i_reg_addr   = '0;
        i_reg_data   = '0;
    endtask

    // One clock of combined core and host traffic; checks the core-side outputs.
    task automatic cycle(input string tag,
                         input logic re, input logic [63:0] ra,
                         input logic we, input logic [63:0] wa, input logic [63:0] wd,
                         input logic [1:0] ctl, input logic [31:0] radr, input logic [31:0] rdat);
        logic set_e;
        logic clr_e;
        i_read_en    = re;
        i_read_addr  = ra;
        i_write_en   = we;
        i_write_addr = wa;
        i_data       = wd;
        i_reg_ctl    = ctl;
        i_reg_addr   = radr;
        i_reg_data   = rdat;
        if (re)
            m_last = oor(ra) ? 64'd0 : m_mem[ra % DEPTH];
        set_e = (re && oor(ra)) || (we && oor(wa));
        clr_e = (ctl == 2'd2) && (radr == 32'd0) && rdat[0];
        tick();
        idle_inputs();
        if (we && !oor(wa))
            m_mem[wa % DEPTH] = wd;
        if (re && m_rcount != 32'hFFFF_FFFF) m_rcount++;
        if (we && m_wcount != 32'hFFFF_FFFF) m_wcount++;
        if (set_e)
            m_err = 1'b1;
        else if (clr_e)
            m_err = 1'b0;
        check({tag, " rvalid"}, 64'(o_rvalid), 64'(re));
        check({tag, " rdata"}, o_data, m_last);
        check({tag, " err"}, 64'(o_err), 64'(m_err));
    endtask

    task automatic idle_cycle(input string tag);
        cycle(tag, 1'b0, '0, 1'b0, '0, '0, 2'd0, '0, '0);
    endtask

    task automatic core_rd(input string tag, input logic [63:0] a);
        cycle(tag, 1'b1, a, 1'b0, '0, '0, 2'd0, '0, '0);
    endtask

    task automatic core_wr(input string tag, input logic [63:0] a, input logic [63:0] d);
        cycle(tag, 1'b0, '0, 1'b1, a, d, 2'd0, '0, '0);
    endtask

    task automatic host_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
        cycle(tag, 1'b0, '0, 1'b0, '0, '0, 2'd2, a, d);
    endtask

    task automatic host_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        cycle(tag, 1'b0, '0, 1'b0, '0, '0, 2'd1, a, '0);
        check({tag, " reg_data"}, 64'(o_reg_data), 64'(exp));
    endtask

    task automatic model_reset();
        m_rcount = '0;
        m_wcount = '0;
        m_err    = 1'b0;
        m_last   = '0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        model_reset();
        idle_inputs();
        i_rst_n = 1'b0;

        // Reset values
        #12;
        check("reset rvalid", 64'(o_rvalid), 64'd0);
        check("reset data", o_data, 64'd0);
        check("reset reg_data", 64'(o_reg_data), 64'd0);
        check("reset err", 64'(o_err), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Write then read back, one-cycle latency, hold, counters
        core_wr("wr5", 64'd5, 64'hDEAD_BEEF_CAFE_F00D);
        core_rd("rd5", 64'd5);
        idle_cycle("rd5 hold");
        host_rd("rcount1", 32'h1, 32'd1);
        host_rd("wcount1", 32'h2, 32'd1);

        // Same-cycle read/write returns pre-write data
        core_wr("wr7 old", 64'd7, 64'h11);
        cycle("rw7", 1'b1, 64'd7, 1'b1, 64'd7, 64'h22, 2'd0, '0, '0);
        core_rd("rd7 new", 64'd7);

        // Out-of-range read, clear, set-wins-over-clear, dropped write
        core_rd("rd oor", 64'h400);
        host_rd("status err", 32'h0, 32'h1);
        host_wr("clr err", 32'h0, 32'h1);
        core_wr("wr0", 64'd0, 64'hAAAA);
        cycle("set wins", 1'b1, 64'h8000_0000_0000_0000, 1'b0, '0, '0, 2'd2, 32'h0, 32'h1);
        host_wr("clr err2", 32'h0, 32'h1);
        core_wr("wr oor", 64'h400, 64'hBAD);
        core_rd("rd0 kept", 64'd0);
        host_wr("clr err3", 32'h0, 32'h1);

        // Host commit held off by continuous core writes; wrap of HADDR
        core_wr("wr3ff old", 64'h3FF, 64'h77);
        host_wr("haddr 3ff", 32'h3, 32'h3FF);
        host_wr("hdata lo", 32'h4, 32'h1);
        host_wr("hdata hi", 32'h5, 32'h2);
        host_wr("cmd commit", 32'h6, 32'h1);
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  ctl;
            logic [31:0] radr;
            ctl  = (i == 0) ? 2'd2 : (i == 1) ? 2'd1 : 2'd0;
            radr = (i == 0) ? 32'h3 : 32'h0;
            cycle("commit stall", 1'b1, 64'h3FF, 1'b1, 64'(10 + i), 64'(i), ctl, radr, 32'h55);
        end
        check("status busy wr", 64'(o_reg_data), 64'h2);
        idle_cycle("commit");
        m_mem[10'h3FF] = 64'h0000_0002_0000_0001;
        core_rd("rd3ff new", 64'h3FF);
        host_rd("haddr wrap", 32'h3, 32'h0);
        host_rd("status idle", 32'h0, 32'h0);

        // Host fetch of word 5
        host_wr("haddr 5", 32'h3, 32'h5);
        host_wr("cmd fetch", 32'h6, 32'h2);
        host_rd("status busy rd", 32'h0, 32'h2);
        idle_cycle("fetch load");
        host_rd("hdata lo 5", 32'h4, 32'hCAFE_F00D);
        host_rd("hdata hi 5", 32'h5, 32'hDEAD_BEEF);
        host_rd("haddr 6", 32'h3, 32'h6);

        // Fetch held off by core reads; writes while busy are ignored
        host_wr("haddr 7", 32'h3, 32'h7);
        host_wr("cmd fetch2", 32'h6, 32'h2);
        cycle("fetch stall a", 1'b1, 64'd5, 1'b0, '0, '0, 2'd2, 32'h6, 32'h1);
        cycle("fetch stall b", 1'b1, 64'd5, 1'b0, '0, '0, 2'd1, 32'h0, 32'h0);
        cycle("fetch stall c", 1'b1, 64'd5, 1'b0, '0, '0, 2'd2, 32'h4, 32'h999);
        check("status busy stall", 64'(o_reg_data), 64'h2);
        idle_cycle("fetch2 read");
        idle_cycle("fetch2 load");
        host_rd("hdata lo 7", 32'h4, 32'h22);
        host_rd("hdata hi 7", 32'h5, 32'h0);
        host_rd("haddr 8", 32'h3, 32'h8);
        host_rd("status idle2", 32'h0, 32'h0);
        host_rd("unmapped", 32'h9, 32'h0);

        // Host commit to an out-of-range HADDR is dropped and flags an error
        host_wr("haddr oor", 32'h3, 32'h400);
        host_wr("hdata lo oor", 32'h4, 32'h5555);
        host_wr("cmd commit oor", 32'h6, 32'h1);
        m_err = 1'b1;
        idle_cycle("commit oor");
        host_rd("haddr after oor", 32'h3, 32'h1);
        core_rd("rd0 after oor", 64'd0);
        host_wr("clr err4", 32'h0, 32'h1);

        // Reset in the middle of a pending commit
        core_wr("wr9", 64'd9, 64'h9999);
        host_wr("haddr 9", 32'h3, 32'h9);
        host_wr("hdata lo 9", 32'h4, 32'hABCD);
        host_wr("cmd commit 9", 32'h6, 32'h1);
        core_wr("hold pend", 64'd20, 64'h20);
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst rvalid", 64'(o_rvalid), 64'd0);
        check("midrst data", o_data, 64'd0);
        check("midrst reg_data", 64'(o_reg_data), 64'd0);
        check("midrst err", 64'(o_err), 64'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        host_rd("post rst status", 32'h0, 32'h0);
        host_rd("post rst haddr", 32'h3, 32'h0);
        host_rd("post rst hdata", 32'h4, 32'h0);
        host_rd("post rst rcount", 32'h1, 32'h0);
        core_rd("rd9 kept", 64'd9);

        // Randomized core traffic with periodic register cross-checks
        for (int a = 0; a < 16; a++)
            core_wr("rand init", 64'(a), {$urandom, $urandom});
        for (int n = 0; n < 400; n++) begin
            logic        re;
            logic        we;
            logic [63:0] ra;
            logic [63:0] wa;
            re = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 15) == 0)
                 ? ((64'd1 << $urandom_range(10, 63)) | 64'($urandom_range(0, 15)))
                 : 64'($urandom_range(0, 15));
            wa = ($urandom_range(0, 15) == 0)
                 ? ((64'd1 << $urandom_range(10, 63)) | 64'($urandom_range(0, 15)))
                 : 64'($urandom_range(0, 15));
            cycle("rand", re, ra, we, wa, {$urandom, $urandom}, 2'd0, '0, '0);
            if (n % 40 == 39) begin
                host_rd("rand rcount", 32'h1, m_rcount);
                host_rd("rand wcount", 32'h2, m_wcount);
                host_rd("rand status", 32'h0, {31'b0, m_err});
                host_wr("rand clr", 32'h0, 32'h1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
